mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (requester C) and a host/testbench loader port (requester H) used for preload and readback.
- Sits between the control/ALU address path and the data memory.
- Issues exactly one memory access per cycle and stalls the core when it loses arbitration.
- Supports host bursts and a starvation limit so neither side can lock the other out.

Parameters:
- AW, 8, address width (matches the ALU result width).
- DW, 8, data width.
- BW, 4, host burst-length field width.
- STARVE_LIM, 4, number of consecutive host-denied cycles after which the host wins one arbitration.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core requests an access this cycle.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core store data.
- core_gnt  out  1  core access performed this cycle.
- core_stall  out  1  core_req && !core_gnt; the PC must hold.
- core_rdata  out  DW  registered load data.
- core_rvalid  out  1  pulses the cycle after a granted core load.
- host_req  in  1  host requests an access.
- host_we  in  1  host write enable.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_burst_len  in  BW  beats to hold the grant; sampled only on the first beat; 0 is treated as 1.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DW  registered host read data.
- host_rvalid  out  1  pulses the cycle after a granted host read.
- host_busy  out  1  a host burst is in progress (state HOST).
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_addr  out  AW  memory address.
- mem_dat_in  out  DW  memory write data.
- mem_dat_out  in  DW  memory read data; combinational, valid in the same cycle as mem_addr.

Behaviour:
- Reset:
  - Asynchronous, active-high; takes effect immediately, including mid-burst.
  - State = IDLE, burst_rem = 0, starve_cnt = 0.
  - core_rdata, host_rdata = 0; core_rvalid, host_rvalid = 0.
  - All grants and memory enables = 0.
- States:
  - IDLE: no burst owner.
  - HOST: burst in progress, burst_rem > 0.
- Grant selection (combinational, zero-bubble):
  - HOST: host_gnt = host_req; core_gnt = 0.
  - IDLE, host wins when host_req && (!core_req || starve_cnt == STARVE_LIM).
  - IDLE, otherwise core_gnt = core_req.
  - Never both grants in the same cycle.
- Memory outputs:
  - Driven from the granted requester: mem_addr, mem_dat_in, mem_wr_en = we, mem_rd_en = !we.
  - With no grant, all memory outputs = 0.
- Read return:
  - On a clock edge where X is granted and not writing: X_rdata <= mem_dat_out, X_rvalid <= 1.
  - Otherwise X_rvalid <= 0 and X_rdata holds its value.
  - Read latency is 1 cycle.
- Burst:
  - First host beat in IDLE: len = (host_burst_len == 0) ? 1 : host_burst_len.
  - If len > 1, go to HOST with burst_rem = len - 1.
  - Each granted beat in HOST decrements burst_rem; go to IDLE when it reaches 0.
  - host_req low in HOST aborts the burst: burst_rem = 0, go to IDLE next cycle. That cycle has no grant.
- Starvation counter:
  - Increments, saturating at STARVE_LIM, on each cycle with host_req && core_gnt.
  - Clears on any host_gnt.
  - Holds otherwise.
- Widths: burst_rem is BW bits; starve_cnt is $clog2(STARVE_LIM+1) bits. No wrap occurs because both counters saturate or reload.
- Simultaneous requests in IDLE with starve_cnt < STARVE_LIM: core wins; host waits.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds 16-bit saturating counters stat_core_grants, stat_host_grants and stat_conflicts (cycles with both requests).
  - Counters are exposed as output ports and cleared by reset.
- Undefined: these ports and the counter logic are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {IDLE, HOST} arb_state_t;
  - typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_HOST} gnt_sel_t;
  - default STARVE_LIM and BW constants.
- One natural sub-module: arb_burst_ctr (burst_rem load/decrement/abort plus starvation counter), instantiated once.
- Grant mux and read-return registers stay in the top of the block.

Test Plan:
1. Reset mid-burst:
   - Stimulus: host burst len=5; assert reset after beat 2.
   - Response: next sample shows IDLE, host_busy=0, all grants and rvalids 0, rdata=0.
2. Core-only load:
   - Stimulus: mem[0x10]=0xA5; core_req=1, we=0, addr=0x10.
   - Response: core_gnt=1 and mem_rd_en=1 the same cycle; next cycle core_rvalid=1, core_rdata=0xA5, core_stall never asserted.
3. Contention with STARVE_LIM=4:
   - Stimulus: core_req and host_req held high continuously.
   - Response: core granted 4 cycles, host granted on the 5th, then the pattern repeats. core_stall=1 exactly on host cycles.
4. Host burst:
   - Stimulus: host_burst_len=3, writes 0x11/0x22/0x33 to 0x20..0x22 while core_req=1.
   - Response: host_gnt for 3 consecutive cycles, host_busy high on cycles 2-3, core stalled 3 cycles; readback returns 0x11, 0x22, 0x33.
5. Burst abort and zero length:
   - Stimulus: len=4 burst with host_req dropped after beat 2; then a request with len=0.
   - Response: abort returns to IDLE with no third beat and core granted the following cycle. len=0 yields exactly one beat with host_busy staying 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
package arb_pkg;

    localparam int ARB_BW         = 4;
    localparam int ARB_STARVE_LIM = 4;

    typedef enum logic {IDLE, HOST} arb_state_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_HOST} gnt_sel_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core, host and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int BW = 4
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [BW-1:0] host_burst_len;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_busy;

    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rdata, core_rvalid,
        input  host_req, host_we, host_addr, host_wdata, host_burst_len,
        output host_gnt, host_rdata, host_rvalid, host_busy,
        output mem_wr_en, mem_rd_en, mem_addr, mem_dat_in,
        input  mem_dat_out
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rdata, core_rvalid,
        output host_req, host_we, host_addr, host_wdata, host_burst_len,
        input  host_gnt, host_rdata, host_rvalid, host_busy,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_dat_in,
        output mem_dat_out
    );
endinterface

// File: rtl/mem_port_arbiter_burst_ctr.sv
// Burst ownership state machine and host starvation counter.
module arb_burst_ctr
    import arb_pkg::*;
#(
    parameter int BW         = ARB_BW,
    parameter int STARVE_LIM = ARB_STARVE_LIM,
    parameter int SW         = $clog2(STARVE_LIM + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_req,
    input  logic          host_gnt,
    input  logic          core_gnt,
    input  logic [BW-1:0] host_burst_len,
    output arb_state_t    state,
    output logic [SW-1:0] starve_cnt
);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    logic [BW-1:0] burst_rem;
    logic [BW-1:0] first_len_s;

    // Zero-length request still moves one beat
    always_comb begin
        if (host_burst_len == '0) begin
            first_len_s = BW'(1);
        end else begin
            first_len_s = host_burst_len;
        end
    end

    // Burst owner FSM: load on first beat, count down, abort when host drops req
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_rem <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_gnt && (first_len_s > BW'(1))) begin
                        state     <= HOST;
                        burst_rem <= first_len_s - BW'(1);
                    end else begin
                        state     <= IDLE;
                        burst_rem <= '0;
                    end
                end
                HOST: begin
                    if (!host_req || (burst_rem == BW'(1))) begin
                        state     <= IDLE;
                        burst_rem <= '0;
                    end else begin
                        state     <= HOST;
                        burst_rem <= burst_rem - BW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_rem <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles the host waited behind the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (host_gnt) begin
            starve_cnt <= '0;
        end else if (host_req && core_gnt && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end else begin
            starve_cnt <= starve_cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory (core vs host loader).
// Define ARB_STATS_EN to add grant/conflict statistics counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int BW         = ARB_BW,
    parameter int STARVE_LIM = ARB_STARVE_LIM
) (
    input  logic                clk,
    input  logic                reset,
`ifdef ARB_STATS_EN
    output logic [15:0]         stat_core_grants,
    output logic [15:0]         stat_host_grants,
    output logic [15:0]         stat_conflicts,
`endif
    mem_port_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    gnt_sel_t      sel_s;
    logic          core_gnt_s;
    logic          host_gnt_s;

    arb_burst_ctr #(
        .BW         (BW),
        .STARVE_LIM (STARVE_LIM),
        .SW         (SW)
    ) u_burst_ctr (
        .clk            (clk),
        .reset          (reset),
        .host_req       (bus.host_req),
        .host_gnt       (host_gnt_s),
        .core_gnt       (core_gnt_s),
        .host_burst_len (bus.host_burst_len),
        .state          (state),
        .starve_cnt     (starve_cnt)
    );

    // Zero-bubble grant choice; a burst owner or a starved host beats the core
    always_comb begin
        sel_s = GNT_NONE;
        if (reset) begin
            sel_s = GNT_NONE;
        end else if (state == HOST) begin
            sel_s = bus.host_req ? GNT_HOST : GNT_NONE;
        end else if (bus.host_req && (!bus.core_req || (starve_cnt == STARVE_MAX))) begin
            sel_s = GNT_HOST;
        end else if (bus.core_req) begin
            sel_s = GNT_CORE;
        end else begin
            sel_s = GNT_NONE;
        end
    end

    assign core_gnt_s     = (sel_s == GNT_CORE);
    assign host_gnt_s     = (sel_s == GNT_HOST);
    assign bus.core_gnt   = core_gnt_s;
    assign bus.host_gnt   = host_gnt_s;
    assign bus.core_stall = bus.core_req & ~core_gnt_s;
    assign bus.host_busy  = (state == HOST);

    // Memory port steered from the granted requester, quiet otherwise
    always_comb begin
        bus.mem_wr_en  = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_dat_in = '0;
        case (sel_s)
            GNT_CORE: begin
                bus.mem_wr_en  = bus.core_we;
                bus.mem_rd_en  = ~bus.core_we;
                bus.mem_addr   = bus.core_addr;
                bus.mem_dat_in = bus.core_wdata;
            end
            GNT_HOST: begin
                bus.mem_wr_en  = bus.host_we;
                bus.mem_rd_en  = ~bus.host_we;
                bus.mem_addr   = bus.host_addr;
                bus.mem_dat_in = bus.host_wdata;
            end
            default: begin
                bus.mem_wr_en  = 1'b0;
                bus.mem_rd_en  = 1'b0;
                bus.mem_addr   = '0;
                bus.mem_dat_in = '0;
            end
        endcase
    end

    // Core read return: capture load data one cycle after the grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.core_rdata  <= '0;
            bus.core_rvalid <= 1'b0;
        end else if (core_gnt_s && !bus.core_we) begin
            bus.core_rdata  <= bus.mem_dat_out;
            bus.core_rvalid <= 1'b1;
        end else begin
            bus.core_rdata  <= bus.core_rdata;
            bus.core_rvalid <= 1'b0;
        end
    end

    // Host read return: same one-cycle latency as the core side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.host_rdata  <= '0;
            bus.host_rvalid <= 1'b0;
        end else if (host_gnt_s && !bus.host_we) begin
            bus.host_rdata  <= bus.mem_dat_out;
            bus.host_rvalid <= 1'b1;
        end else begin
            bus.host_rdata  <= bus.host_rdata;
            bus.host_rvalid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating grant and conflict statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_core_grants <= 16'd0;
            stat_host_grants <= 16'd0;
            stat_conflicts   <= 16'd0;
        end else begin
            stat_core_grants <= core_gnt_s ? sat_inc16(stat_core_grants) : stat_core_grants;
            stat_host_grants <= host_gnt_s ? sat_inc16(stat_host_grants) : stat_host_grants;
            stat_conflicts   <= (bus.core_req && bus.host_req) ? sat_inc16(stat_conflicts)
                                                               : stat_conflicts;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural memory.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [DW-1:0] mem [256];

    mem_port_arbiter_if #(.AW(AW), .DW(DW), .BW(BW)) bus();

`ifdef ARB_STATS_EN
    logic [15:0] stat_core_grants;
    logic [15:0] stat_host_grants;
    logic [15:0] stat_conflicts;
`endif

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .BW(BW), .STARVE_LIM(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef ARB_STATS_EN
        .stat_core_grants (stat_core_grants),
        .stat_host_grants (stat_host_grants),
        .stat_conflicts   (stat_conflicts),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.mem_dat_out = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        bus.core_req       = 1'b0;
        bus.core_we        = 1'b0;
        bus.core_addr      = 8'h00;
        bus.core_wdata     = 8'h00;
        bus.host_req       = 1'b0;
        bus.host_we        = 1'b0;
        bus.host_addr      = 8'h00;
        bus.host_wdata     = 8'h00;
        bus.host_burst_len = 4'd1;
        #1;
        check("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        check("rst_core_rdata",  32'(bus.core_rdata),  32'd0);
        check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("rst_host_busy",   32'(bus.host_busy),   32'd0);
        check("rst_mem_wr_en",   32'(bus.mem_wr_en),   32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Preload 0xA5 at 0x10 through a single host write
        bus.host_req = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 8'h10; bus.host_wdata = 8'hA5;
        #1;
        check("pre_host_gnt",  32'(bus.host_gnt),  32'd1);
        check("pre_mem_wr_en", 32'(bus.mem_wr_en), 32'd1);
        check("pre_mem_addr",  32'(bus.mem_addr),  32'h10);
        tick();
        bus.host_req = 1'b0;

        // Core-only load
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10;
        #1;
        check("cload_gnt",   32'(bus.core_gnt),   32'd1);
        check("cload_rd_en", 32'(bus.mem_rd_en),  32'd1);
        check("cload_stall", 32'(bus.core_stall), 32'd0);
        tick();
        check("cload_rvalid", 32'(bus.core_rvalid), 32'd1);
        check("cload_rdata",  32'(bus.core_rdata),  32'hA5);
        bus.core_req = 1'b0;
        tick();
        check("cload_rvalid_drop", 32'(bus.core_rvalid), 32'd0);

        // Contention: four core cycles then one host cycle, repeating
        bus.core_req = 1'b1; bus.core_addr = 8'h10;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h10;
        bus.host_burst_len = 4'd1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check($sformatf("cont_core_gnt_%0d", i),  32'(bus.core_gnt),   (i % 5 != 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_host_gnt_%0d", i),  32'(bus.host_gnt),   (i % 5 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_stall_%0d", i),     32'(bus.core_stall), (i % 5 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_h_rvalid_%0d", i),  32'(bus.host_rvalid),
                  (i > 1 && (i - 1) % 5 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_c_rvalid_%0d", i),  32'(bus.core_rvalid),
                  (i > 1 && (i - 1) % 5 != 0) ? 32'd1 : 32'd0);
            tick();
        end
        check("cont_host_rdata", 32'(bus.host_rdata), 32'hA5);

        // Host burst of 3 writes against a busy core; host takes over after starving
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_burst_len = 4'd3;
        begin
            int beat;
            beat = 0;
            for (int c = 1; c <= 7; c++) begin
                bus.host_addr  = 8'h20 + 8'(beat);
                bus.host_wdata = 8'h11 * 8'(beat + 1);
                #1;
                check($sformatf("burst_host_gnt_%0d", c), 32'(bus.host_gnt),   (c >= 5) ? 32'd1 : 32'd0);
                check($sformatf("burst_core_gnt_%0d", c), 32'(bus.core_gnt),   (c < 5)  ? 32'd1 : 32'd0);
                check($sformatf("burst_stall_%0d", c),    32'(bus.core_stall), (c >= 5) ? 32'd1 : 32'd0);
                check($sformatf("burst_busy_%0d", c),     32'(bus.host_busy),  (c >= 6) ? 32'd1 : 32'd0);
                if (c >= 5) beat++;
                tick();
            end
        end
        bus.core_req = 1'b0;

        // Host readback of the burst
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_burst_len = 4'd1;
        for (int k = 0; k < 3; k++) begin
            bus.host_addr = 8'h20 + 8'(k);
            #1;
            check($sformatf("rb_gnt_%0d", k), 32'(bus.host_gnt), 32'd1);
            tick();
            check($sformatf("rb_rvalid_%0d", k), 32'(bus.host_rvalid), 32'd1);
            check($sformatf("rb_rdata_%0d", k),  32'(bus.host_rdata),  32'(8'h11 * 8'(k + 1)));
        end
        bus.host_req = 1'b0;
        tick();

        // Burst of 4 aborted after two beats
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_burst_len = 4'd4;
        bus.host_addr = 8'h40; bus.host_wdata = 8'h44;
        #1;
        check("abort_b1_gnt",  32'(bus.host_gnt),  32'd1);
        check("abort_b1_busy", 32'(bus.host_busy), 32'd0);
        tick();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h20;
        bus.host_addr = 8'h41; bus.host_wdata = 8'h55;
        #1;
        check("abort_b2_gnt",   32'(bus.host_gnt),   32'd1);
        check("abort_b2_stall", 32'(bus.core_stall), 32'd1);
        check("abort_b2_busy",  32'(bus.host_busy),  32'd1);
        tick();
        bus.host_req = 1'b0;
        #1;
        check("abort_gap_host_gnt", 32'(bus.host_gnt),   32'd0);
        check("abort_gap_core_gnt", 32'(bus.core_gnt),   32'd0);
        check("abort_gap_stall",    32'(bus.core_stall), 32'd1);
        check("abort_gap_wr_en",    32'(bus.mem_wr_en),  32'd0);
        tick();
        check("abort_core_gnt",  32'(bus.core_gnt),   32'd1);
        check("abort_idle_busy", 32'(bus.host_busy),  32'd0);
        check("abort_no_stall",  32'(bus.core_stall), 32'd0);
        tick();
        check("abort_core_rvalid", 32'(bus.core_rvalid), 32'd1);
        check("abort_core_rdata",  32'(bus.core_rdata),  32'h11);
        bus.core_req = 1'b0;

        // Zero burst length gives one beat and no busy
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h40;
        bus.host_burst_len = 4'd0;
        #1;
        check("zlen_gnt",   32'(bus.host_gnt),  32'd1);
        check("zlen_busy",  32'(bus.host_busy), 32'd0);
        check("zlen_rd_en", 32'(bus.mem_rd_en), 32'd1);
        tick();
        bus.host_req = 1'b0;
        #1;
        check("zlen_busy_after", 32'(bus.host_busy),   32'd0);
        check("zlen_gnt_after",  32'(bus.host_gnt),    32'd0);
        check("zlen_rvalid",     32'(bus.host_rvalid), 32'd1);
        check("zlen_rdata",      32'(bus.host_rdata),  32'h44);
        tick();

        // Reset in the middle of a 5-beat host read burst
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_burst_len = 4'd5;
        bus.host_addr = 8'h20;
        #1;
        check("mrst_b1_gnt", 32'(bus.host_gnt), 32'd1);
        tick();
        bus.host_addr = 8'h21;
        #1;
        check("mrst_b2_busy", 32'(bus.host_busy), 32'd1);
        tick();
        check("mrst_b2_rdata", 32'(bus.host_rdata), 32'h22);
        reset = 1'b1;
        #1;
        check("mrst_busy",        32'(bus.host_busy),   32'd0);
        check("mrst_host_gnt",    32'(bus.host_gnt),    32'd0);
        check("mrst_core_gnt",    32'(bus.core_gnt),    32'd0);
        check("mrst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("mrst_host_rdata",  32'(bus.host_rdata),  32'd0);
        check("mrst_core_rdata",  32'(bus.core_rdata),  32'd0);
        check("mrst_rd_en",       32'(bus.mem_rd_en),   32'd0);
        tick();
        bus.host_req = 1'b0;
        reset = 1'b0;
        tick();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10;
        #1;
        check("post_rst_core_gnt", 32'(bus.core_gnt), 32'd1);
        tick();
        check("post_rst_rdata", 32'(bus.core_rdata), 32'hA5);
        bus.core_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
